// File: rtl/nand_proc_pkg.sv
// Shared definitions for the parametrised NAND/branch processor: state encoding,
// instruction field positions and register-map bases.
package nand_proc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    RUN,
    HALT
  } state_t;

  localparam int OPC_BIT    = 0;
  localparam int FIELD_LSB  = 1;
  localparam int CONST_ADDR = 0;
  localparam int IN_BASE    = 1;

  function automatic int instr_w(input int reg_aw);
    return 1 + 3 * reg_aw;
  endfunction

  function automatic int mag_w(input int reg_aw);
    return 2 * reg_aw - 1;
  endfunction

  // NAND form: srcA at FIELD_LSB, srcB and dst follow in REG_AW-wide slots
  function automatic int src_b_lsb(input int reg_aw);
    return FIELD_LSB + reg_aw;
  endfunction

  function automatic int dst_lsb(input int reg_aw);
    return FIELD_LSB + 2 * reg_aw;
  endfunction

  // Branch form: cond at FIELD_LSB, then the direction bit, then the magnitude
  function automatic int dir_bit(input int reg_aw);
    return FIELD_LSB + reg_aw;
  endfunction

  function automatic int mag_lsb(input int reg_aw);
    return FIELD_LSB + reg_aw + 1;
  endfunction

  function automatic int out_base(input int num_in);
    return IN_BASE + num_in;
  endfunction

  function automatic int int_base(input int num_in, input int num_out);
    return IN_BASE + num_in + num_out;
  endfunction

endpackage

// File: rtl/nand_processor_w_if.sv
// Program-load and register I/O bundle of the NAND processor; the core is the slave.
interface nand_processor_w_if #(
  parameter int DATA_W  = 4,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 7,
  parameter int PC_W    = 8
);
  logic                        load_en;
  logic                        load_bit;
  logic [NUM_IN*DATA_W-1:0]    in_data;
  logic [NUM_OUT*DATA_W-1:0]   out_data;
  logic [PC_W-1:0]             pc;
  logic                        running;
  logic                        halted;
  logic                        load_overflow;

  modport master (
    output load_en, load_bit, in_data,
    input  out_data, pc, running, halted, load_overflow
  );

  modport slave (
    input  load_en, load_bit, in_data,
    output out_data, pc, running, halted, load_overflow
  );
endinterface

// File: rtl/nand_prog_loader.sv
// Serial program loader: assembles LSB-first instruction words, commits each complete
// word to instruction memory, and tracks program length and overflow.
module nand_prog_loader #(
  parameter int INSTR_W = 13,
  parameter int PC_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               shift_en,
  input  logic               load_bit,
  output logic               mem_we,
  output logic [PC_W-1:0]    mem_waddr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic [PC_W:0]      prog_len,
  output logic               load_overflow
);
  localparam int                BIT_CW   = $clog2(INSTR_W);
  localparam logic [PC_W:0]     DEPTH    = (PC_W+1)'(2**PC_W);
  localparam logic [PC_W:0]     WORD_ONE = (PC_W+1)'(1);
  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(INSTR_W-1);
  localparam logic [BIT_CW-1:0] BIT_ONE  = BIT_CW'(1);

  logic [BIT_CW-1:0]  bit_cnt_reg;
  logic [PC_W:0]      word_cnt_reg;
  logic [PC_W:0]      prog_len_reg;
  logic [INSTR_W-2:0] shift_reg;
  logic               overflow_reg;
  logic               mem_full;
  logic               last_bit;

  assign mem_full      = (word_cnt_reg == DEPTH);
  assign last_bit      = (bit_cnt_reg == LAST_BIT);
  // The final bit goes straight into the write data, so the word commits on its own edge
  assign mem_we        = shift_en && !mem_full && last_bit;
  assign mem_waddr     = word_cnt_reg[PC_W-1:0];
  assign mem_wdata     = {load_bit, shift_reg};
  assign prog_len      = prog_len_reg;
  assign load_overflow = overflow_reg;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      prog_len_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (shift_en) begin
      if (mem_full) begin
        overflow_reg <= 1'b1;
      end else if (last_bit) begin
        bit_cnt_reg  <= '0;
        word_cnt_reg <= word_cnt_reg + WORD_ONE;
        prog_len_reg <= word_cnt_reg + WORD_ONE;
      end else begin
        shift_reg[bit_cnt_reg] <= load_bit;
        bit_cnt_reg            <= bit_cnt_reg + BIT_ONE;
      end
    end
  end

endmodule

// File: rtl/nand_processor_w.sv
// DATA_W-bit NAND/branch processor with serially loaded instruction memory,
// linear register map (constant, inputs, outputs, internals) and registered outputs.
module nand_processor_w
  import nand_proc_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 7,
  parameter int NUM_INT = 6,
  parameter int REG_AW  = 4,
  parameter int PC_W    = 8
) (
  input  logic clk,
  input  logic reset,
  nand_processor_w_if.slave bus
);
  localparam int INSTR_W  = instr_w(REG_AW);
  localparam int MAG_W    = mag_w(REG_AW);
  localparam int NUM_REGS = 2**REG_AW;
  localparam int OUT_BASE = out_base(NUM_IN);
  localparam int INT_BASE = int_base(NUM_IN, NUM_OUT);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t               state_reg, state_next;
  logic [PC_W-1:0]      pc_reg, pc_next;
  logic [INSTR_W-1:0]   imem [2**PC_W];
  logic [INSTR_W-1:0]   instr_reg;
  logic [DATA_W-1:0]    out_reg [NUM_OUT];
  logic [DATA_W-1:0]    int_reg [NUM_INT];
  logic [DATA_W-1:0]    rf_view [NUM_REGS];
  logic [NUM_OUT-1:0]   out_we;
  logic [NUM_INT-1:0]   int_we;

  logic                 mem_we;
  logic [PC_W-1:0]      mem_waddr;
  logic [INSTR_W-1:0]   mem_wdata;
  logic [PC_W:0]        prog_len;
  logic                 load_start;
  logic                 load_shift;
  logic                 wr_en;

  logic                 is_nand;
  logic [REG_AW-1:0]    src_a, src_b, dst, cond;
  logic                 dir;
  logic [MAG_W-1:0]     mag;
  logic [PC_W-1:0]      mag_pc;
  logic [DATA_W-1:0]    nand_res;
  logic [DATA_W-1:0]    cond_val;

  assign is_nand  = instr_reg[OPC_BIT];
  assign src_a    = instr_reg[FIELD_LSB +: REG_AW];
  assign src_b    = instr_reg[src_b_lsb(REG_AW) +: REG_AW];
  assign dst      = instr_reg[dst_lsb(REG_AW) +: REG_AW];
  assign cond     = instr_reg[FIELD_LSB +: REG_AW];
  assign dir      = instr_reg[dir_bit(REG_AW)];
  assign mag      = instr_reg[mag_lsb(REG_AW) +: MAG_W];
  // Branch arithmetic is modulo 2**PC_W, so the magnitude is folded to PC width
  assign mag_pc   = PC_W'(mag);
  assign nand_res = ~(rf_view[src_a] & rf_view[src_b]);
  assign cond_val = rf_view[cond];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_view
    if (gi == CONST_ADDR) begin : g_const
      assign rf_view[gi] = '1;
    end else if (gi < OUT_BASE) begin : g_in
      assign rf_view[gi] = bus.in_data[(gi-IN_BASE)*DATA_W +: DATA_W];
    end else if (gi < INT_BASE) begin : g_out
      assign rf_view[gi] = out_reg[gi-OUT_BASE];
    end else if (gi < INT_BASE + NUM_INT) begin : g_int
      assign rf_view[gi] = int_reg[gi-INT_BASE];
    end else begin : g_unmapped
      assign rf_view[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out_we
    assign out_we[gi] = wr_en && (dst == REG_AW'(OUT_BASE + gi));
    assign bus.out_data[gi*DATA_W +: DATA_W] = out_reg[gi];
  end

  for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_int_we
    assign int_we[gi] = wr_en && (dst == REG_AW'(INT_BASE + gi));
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    wr_en      = 1'b0;
    load_start = 1'b0;
    case (state_reg)
      IDLE, HALT: begin
        if (bus.load_en) begin
          state_next = LOADING;
          load_start = 1'b1;
        end
      end
      LOADING: begin
        if (!bus.load_en) begin
          state_next = RUN;
          pc_next    = '0;
        end
      end
      RUN: begin
        if (bus.load_en) begin
          state_next = LOADING;
          load_start = 1'b1;
        end else if ({1'b0, pc_reg} >= prog_len) begin
          state_next = HALT;
        end else if (is_nand) begin
          wr_en   = 1'b1;
          pc_next = pc_reg + PC_ONE;
        end else if (cond_val == '0) begin
          pc_next = pc_reg + PC_ONE;
        end else if (mag == '0) begin
          state_next = HALT;
        end else if (dir) begin
          pc_next = pc_reg - mag_pc;
        end else begin
          pc_next = pc_reg + mag_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_shift = (state_reg == LOADING) && bus.load_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Reading at pc_next keeps the registered fetch aligned with the current pc
  always_ff @(posedge clk) begin
    if (mem_we) begin
      imem[mem_waddr] <= mem_wdata;
    end
    instr_reg <= imem[pc_next];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT; i++) out_reg[i] <= '0;
      for (int i = 0; i < NUM_INT; i++) int_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) if (out_we[i]) out_reg[i] <= nand_res;
      for (int i = 0; i < NUM_INT; i++) if (int_we[i]) int_reg[i] <= nand_res;
    end
  end

  nand_prog_loader #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_loader (
    .clk           (clk),
    .reset         (reset),
    .start         (load_start),
    .shift_en      (load_shift),
    .load_bit      (bus.load_bit),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .prog_len      (prog_len),
    .load_overflow (bus.load_overflow)
  );

  assign bus.pc      = pc_reg;
  assign bus.running = (state_reg == RUN);
  assign bus.halted  = (state_reg == HALT);

endmodule

// File: tb/tb_nand_processor_w.sv
// Directed bench for nand_processor_w: stimulus queues expected pc traces and halt
// results; a negedge monitor pops and compares them as the core runs and halts.
module tb_nand_processor_w;
  localparam int DATA_W  = 4;
  localparam int NUM_IN  = 2;
  localparam int NUM_OUT = 7;
  localparam int NUM_INT = 6;
  localparam int REG_AW  = 4;
  localparam int PC_W    = 8;
  localparam int PC_W2   = 2;
  localparam int INSTR_W = 13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nand_processor_w_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .PC_W(PC_W))  bus ();
  nand_processor_w_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .PC_W(PC_W2)) bus2 ();

  nand_processor_w #(
    .DATA_W(DATA_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT),
    .NUM_INT(NUM_INT), .REG_AW(REG_AW), .PC_W(PC_W)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  nand_processor_w #(
    .DATA_W(DATA_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT),
    .NUM_INT(NUM_INT), .REG_AW(REG_AW), .PC_W(PC_W2)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    string                     name;
    logic [31:0]               pc;
    logic [NUM_OUT*DATA_W-1:0] out_data;
  } result_t;

  int unsigned         trace_q[$];
  result_t             result_q[$];
  logic [INSTR_W-1:0]  prog_q[$];
  int                  n_cmp = 0;
  int                  n_bad = 0;
  logic                halted_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_trace(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) trace_q.push_back(p);
  endtask

  task automatic expect_halt(input string name, input int pc, input logic [NUM_OUT*DATA_W-1:0] od);
    result_t r;
    r.name = name;
    r.pc = 32'(pc);
    r.out_data = od;
    result_q.push_back(r);
  endtask

  // Scoreboard monitor for the main core
  always @(negedge clk) begin
    result_t r;
    if (bus.running) begin
      if (trace_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pc trace: got unexpected run cycle at pc 0x%0h, expected no run", bus.pc);
      end else begin
        check("pc trace", 32'(bus.pc), trace_q.pop_front());
      end
    end
    if (bus.halted && !halted_prev) begin
      if (result_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL halt event: got unexpected halt at pc 0x%0h, expected none", bus.pc);
      end else begin
        r = result_q.pop_front();
        check({r.name, " halt pc"}, 32'(bus.pc), r.pc);
        check({r.name, " out_data"}, 32'(bus.out_data), 32'(r.out_data));
        $display("halt %s: pc=%0d out_data=0x%07h", r.name, bus.pc, bus.out_data);
      end
    end
    halted_prev = bus.halted;
  end

  task automatic drive(input int sel, input logic en, input logic b);
    if (sel == 0) begin
      bus.load_en  = en;
      bus.load_bit = b;
    end else begin
      bus2.load_en  = en;
      bus2.load_bit = b;
    end
  endtask

  // One edge enters LOADING, then one bit per edge; returns just after the RUN-entry edge
  task automatic load_prog(input int sel, input int nbits);
    logic [INSTR_W-1:0] w;
    int n;
    n = (nbits < 0) ? prog_q.size() * INSTR_W : nbits;
    drive(sel, 1'b1, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      w = prog_q[i / INSTR_W];
      drive(sel, 1'b1, w[i % INSTR_W]);
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 1'b0);
    @(posedge clk); #1;
    $display("load dut%0d: %0d bits", sel, n);
  endtask

  task automatic wait_halt(input int sel, input string name);
    int k;
    k = 0;
    while (((sel == 0) ? bus.halted : bus2.halted) !== 1'b1 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (((sel == 0) ? bus.halted : bus2.halted) !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no halt after %0d cycles, expected halt", name, k);
    end
    @(negedge clk); #1;
  endtask

  task automatic drain(input string name);
    check({name, " trace drained"}, 32'(trace_q.size()), 32'd0);
    check({name, " halts drained"}, 32'(result_q.size()), 32'd0);
    trace_q.delete();
    result_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    bus.in_data  = '0;
    bus2.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset while an endless NAND/branch-back loop runs
    bus.in_data = 8'h3A;
    prog_q = {13'h0603, 13'h0060};
    push_trace(0, 1);
    push_trace(0, 1);
    load_prog(0, -1);
    repeat (3) @(posedge clk);
    #1;
    check("loop out_data before reset", 32'(bus.out_data), 32'h5);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset out_data", 32'(bus.out_data), 32'h0);
    check("reset pc", 32'(bus.pc), 32'h0);
    check("reset running", 32'(bus.running), 32'h0);
    check("reset halted", 32'(bus.halted), 32'h0);
    check("reset load_overflow", 32'(bus.load_overflow), 32'h0);
    reset = 1'b0;
    drain("reset");

    // Single NAND then halt on constant
    do_reset();
    bus.in_data = 8'h3A;
    prog_q = {13'h0603, 13'h0000};
    push_trace(0, 1);
    expect_halt("single nand", 1, 28'h5);
    load_prog(0, -1);
    wait_halt(0, "single nand");
    drain("single nand");

    // Three-stage token counter a<-b<-c<-0, branching back while a != 0; out0 toggles per pass
    do_reset();
    bus.in_data = 8'h00;
    prog_q = {13'h1A01, 13'h15BB, 13'h16BB, 13'h18BB,
              13'h0607, 13'h1A17, 13'h141B, 13'h1A19, 13'h161B, 13'h1801, 13'h01B4,
              13'h0000};
    push_trace(0, 3);
    for (int it = 0; it < 3; it++) push_trace(4, 10);
    push_trace(11, 11);
    expect_halt("backward loop", 11, 28'hF);
    load_prog(0, -1);
    wait_halt(0, "backward loop");
    drain("backward loop");

    // Writes to constant and input are dropped; outputs read both back through NAND
    do_reset();
    bus.in_data = 8'h06;
    prog_q = {13'h0001, 13'h0201, 13'h0621, 13'h0823, 13'h0000};
    push_trace(0, 4);
    expect_halt("protected", 4, 28'h99);
    load_prog(0, -1);
    wait_halt(0, "protected");
    bus.in_data = 8'h03;
    push_trace(0, 4);
    expect_halt("protected reload", 4, 28'hCC);
    load_prog(0, -1);
    wait_halt(0, "protected reload");
    drain("protected");

    // 20 bits: one full word plus a discarded fragment; run-off halts at pc 1
    do_reset();
    bus.in_data = 8'h0A;
    prog_q = {13'h0603, 13'h0823};
    push_trace(0, 1);
    expect_halt("partial word", 1, 28'h5);
    load_prog(0, 20);
    wait_halt(0, "partial word");
    drain("partial word");

    // Four-deep memory, five words loaded
    do_reset();
    bus2.in_data = 8'hCA;
    prog_q = {13'h0603, 13'h0805, 13'h0A43, 13'h0000, 13'h1FFF};
    load_prog(1, -1);
    check("overflow flag", 32'(bus2.load_overflow), 32'h1);
    check("overflow prog_len", 32'(u_dut2.u_loader.prog_len), 32'd4);
    wait_halt(1, "overflow run");
    check("overflow halted", 32'(bus2.halted), 32'h1);
    check("overflow halt pc", 32'(bus2.pc), 32'd3);
    check("overflow out_data", 32'(bus2.out_data), 32'h735);
    check("overflow sticky", 32'(bus2.load_overflow), 32'h1);
    $display("overflow run: pc=%0d out_data=0x%07h", bus2.pc, bus2.out_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nand_processor_w.md
Name: nand_processor_w

Overview:
Parametrised successor to the one-bit NAND/branch processor: DATA_W-bit registers with bitwise NAND, a configurable register file, and a configurable instruction memory depth. Programs are loaded serially, one bit per clock, while load_en is high. Execution starts from address 0 when load_en falls and halts on an explicit halt instruction or when the PC leaves the loaded program. Sits at the same position in the design as the one-bit core: top-level I/O driving output registers.

Parameters:
DATA_W, 4, width of every register and of the datapath
NUM_IN, 2, number of read-only input registers
NUM_OUT, 7, number of output registers
NUM_INT, 6, number of internal registers
REG_AW, 4, register address width; 1+NUM_IN+NUM_OUT+NUM_INT <= 2**REG_AW
PC_W, 8, program counter width; instruction memory depth = 2**PC_W
(derived) INSTR_W = 1+3*REG_AW (13); MAG_W = 2*REG_AW-1 (7)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
load_en  in  1  high = serial program load mode
load_bit  in  1  serial instruction bit, LSB of each word first
in_data  in  NUM_IN*DATA_W  input registers; reg k at bits [k*DATA_W +: DATA_W]
out_data  out  NUM_OUT*DATA_W  output registers, same packing
pc  out  PC_W  current program counter
running  out  1  in RUN state
halted  out  1  in HALT state
load_overflow  out  1  sticky: load attempted beyond memory depth

Behaviour:
- One clock; reset is synchronous and active-high. Reset sets state=IDLE, pc=0, out_data=0, internal regs=0, prog_len=0, load_overflow=0. Instruction memory contents are not cleared.
- Register map (linear): addr 0 = constant all-ones (read-only); 1..NUM_IN = inputs (read-only); next NUM_OUT = outputs; next NUM_INT = internal. Unmapped addresses read 0. Writes to read-only or unmapped addresses are ignored.
- Instruction bit 0 selects the form.
  - bit0=1, NAND: [4:1]=srcA, [8:5]=srcB, [12:9]=dst. dst <= ~(A & B) bitwise; pc <= pc+1. Generalised to REG_AW-wide fields.
  - bit0=0, BRANCH: [4:1]=cond reg, [5]=dir (1=backward), [12:6]=mag (MAG_W bits). Taken iff cond reg != 0.
    - Taken: pc <= pc ± mag, modulo 2**PC_W.
    - Not taken: pc <= pc+1.
    - Taken with mag=0: HALT. pc is held and no register is written.
- States:
  - IDLE -> LOADING when load_en=1.
  - LOADING -> RUN when load_en=0; pc=0 on entry to RUN.
  - RUN -> HALT on a halt instruction, or when pc >= prog_len at fetch (nothing executed, pc held).
  - RUN/HALT -> LOADING when load_en=1; registers are retained.
- Entering LOADING clears the bit counter, word counter, prog_len and load_overflow.
- Loading: each cycle in LOADING, load_bit is written to the current bit of the current word.
  - After INSTR_W bits the word commits: word counter +1 and prog_len = word counter.
  - A partial final word is discarded when load_en falls; prog_len counts complete words only.
  - Bits arriving after 2**PC_W complete words are ignored and set load_overflow.
- Timing: one instruction per clock. A register write is visible to the next instruction's read. Outputs are registered.
- No execution or register writes occur in IDLE, LOADING or HALT.
- Reset asserted mid-load or mid-run overrides everything in the same edge.

Decomposition:
- Shared package nand_proc_pkg: opcode bit position, field offsets as functions of REG_AW, the state enum (IDLE/LOADING/RUN/HALT), and address-base constants (CONST_ADDR=0, IN_BASE=1, OUT_BASE=1+NUM_IN, INT_BASE=1+NUM_IN+NUM_OUT).
- One sub-module, nand_prog_loader: the serial bit/word counters, memory write port, prog_len and overflow flag.

Test Plan:
- Reset: assert reset during RUN -> next cycle out_data=0, pc=0, running=0, halted=0, load_overflow=0.
- Single NAND: load word 0 = 0x0603 (A=in0, B=const, dst=out0) and word 1 = 0x0000 (halt on const) with in0=4'hA -> out0=4'h5 one cycle into RUN, then halted=1 with pc=1.
- Backward loop: program decrements an internal reg from 4'h3 using NAND sequences and branches backward (dir=1, mag=k) while it is nonzero -> pc trace repeats exactly 3 times, then falls through to halt.
- Protected writes: NAND with dst=0 or dst=1 -> constant still reads 4'hF and in0 still follows in_data; all other regs unchanged.
- Partial word and run-off: load 20 bits -> prog_len=1; after word 0 (a NAND) executes, fetch at pc=1 halts with halted=1 and pc=1.
- Overflow: PC_W=2, load 5 full words -> load_overflow=1, prog_len=4, words 0-3 intact.
